// File: rtl/semi_cmd_encoder.sv
// Direction push-button front-end: synchronise, debounce, arbitrate and stretch commands for the semi-auto FSM.
// Defining SEMI_CMD_AUTOREPEAT_EN re-issues the latched command while its button stays held.
module semi_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int HOLD_CYCLES     = 2_000_000,
    parameter int REPEAT_CYCLES   = 100_000_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic semi_auto_mode_on,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_straight,
    input  logic btn_back,
    output logic turn_left_command,
    output logic turn_right_command,
    output logic go_straight_command,
    output logic turn_back_command,
    output logic cmd_busy
);
    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
    typedef enum logic [1:0] {
        BTN_LEFT     = 2'd0,
        BTN_RIGHT    = 2'd1,
        BTN_STRAIGHT = 2'd2,
        BTN_BACK     = 2'd3
    } btn_t;

    localparam int MAX_A     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_COUNT = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    if (CNT_W < $clog2(MAX_COUNT + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] ONE       = 1;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [3:0]       raw, sync1, sync2, deb, deb_q, req;
    logic [CNT_W-1:0] db_cnt [4];

    assign raw = {btn_back, btn_straight, btn_right, btn_left};

    // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + ONE;
                end
            end
        end
    end

    // Combinational against the registered previous level: one request cycle per debounced press.
    assign req = deb & ~deb_q;

    btn_t pick;
    always_comb begin
        if      (req[BTN_STRAIGHT]) pick = BTN_STRAIGHT;
        else if (req[BTN_RIGHT])    pick = BTN_RIGHT;
        else if (req[BTN_LEFT])     pick = BTN_LEFT;
        else                        pick = BTN_BACK;
    end

    state_t           state, state_n;
    logic [3:0]       out_q, out_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
`ifdef SEMI_CMD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    btn_t             latched, latched_n;
    logic [CNT_W-1:0] rep_cnt, rep_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_q    <= '0;
            hold_cnt <= '0;
`ifdef SEMI_CMD_AUTOREPEAT_EN
            latched  <= BTN_LEFT;
            rep_cnt  <= '0;
`endif
        end else begin
            state    <= state_n;
            out_q    <= out_n;
            hold_cnt <= hold_n;
`ifdef SEMI_CMD_AUTOREPEAT_EN
            latched  <= latched_n;
            rep_cnt  <= rep_n;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        out_n   = out_q;
        hold_n  = hold_cnt;
`ifdef SEMI_CMD_AUTOREPEAT_EN
        latched_n = latched;
        rep_n     = rep_cnt;
`endif
        if (!semi_auto_mode_on) begin
            state_n = IDLE;
            out_n   = '0;
            hold_n  = '0;
`ifdef SEMI_CMD_AUTOREPEAT_EN
            rep_n   = '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    out_n = '0;
                    if (|req) begin
                        out_n[pick] = 1'b1;
                        hold_n      = '0;
                        state_n     = HOLD;
`ifdef SEMI_CMD_AUTOREPEAT_EN
                        latched_n   = pick;
`endif
                    end
                end
                HOLD: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        out_n   = '0;
                        state_n = RELEASE;
`ifdef SEMI_CMD_AUTOREPEAT_EN
                        rep_n   = '0;
`endif
                    end else begin
                        hold_n = hold_cnt + ONE;
                    end
                end
                RELEASE: begin
`ifdef SEMI_CMD_AUTOREPEAT_EN
                    if (deb[latched]) begin
                        if (rep_cnt >= REP_LAST) begin
                            out_n[latched] = 1'b1;
                            hold_n         = '0;
                            rep_n          = '0;
                            state_n        = HOLD;
                        end else begin
                            rep_n = rep_cnt + ONE;
                        end
                    end else begin
                        rep_n = '0;
                        if (deb == 4'b0000) state_n = IDLE;
                    end
`else
                    if (deb == 4'b0000) state_n = IDLE;
`endif
                end
                default: begin
                    state_n = IDLE;
                    out_n   = '0;
                end
            endcase
        end
    end

    assign turn_left_command   = out_q[BTN_LEFT];
    assign turn_right_command  = out_q[BTN_RIGHT];
    assign go_straight_command = out_q[BTN_STRAIGHT];
    assign turn_back_command   = out_q[BTN_BACK];
    assign cmd_busy            = (state != IDLE);
endmodule

// File: tb/tb_semi_cmd_encoder.sv
// Bench for semi_cmd_encoder: directed scenarios plus randomized buttons/mode/reset,
// every cycle compared against a behavioural model of the command rules.
module tb_semi_cmd_encoder;
    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic semi_auto_mode_on = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_straight = 1'b0, btn_back = 1'b0;
    logic turn_left_command, turn_right_command, go_straight_command, turn_back_command, cmd_busy;

    int checks = 0;
    int failures = 0;

    semi_cmd_encoder #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .semi_auto_mode_on(semi_auto_mode_on),
        .btn_left(btn_left), .btn_right(btn_right), .btn_straight(btn_straight), .btn_back(btn_back),
        .turn_left_command(turn_left_command), .turn_right_command(turn_right_command),
        .go_straight_command(go_straight_command), .turn_back_command(turn_back_command),
        .cmd_busy(cmd_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: button index 0=left 1=right 2=straight 3=back, -1 = no command.
    int m_s1[4], m_s2[4], m_deb[4], m_debp[4], m_run[4];
    int m_busy_mode;   // 0 idle, 1 command showing, 2 waiting for release
    int m_cmd, m_out, m_hold_left, m_rep;

    // Scenario statistics over the outputs.
    int hi_cnt[4], rise_cnt[4];
    logic [3:0] prev_outs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit mode, input bit [3:0] raw);
        int req[4];
        int order[4];
        bit all_low;
        order = '{2, 1, 0, 3};
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_run[i] = 0;
            end
            m_busy_mode = 0; m_cmd = -1; m_out = -1; m_hold_left = 0; m_rep = 0;
            return;
        end
        all_low = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req[i] = (m_deb[i] == 1 && m_debp[i] == 0) ? 1 : 0;
            if (m_deb[i] != 0) all_low = 1'b0;
        end
        if (!mode) begin
            m_busy_mode = 0; m_out = -1; m_rep = 0;
        end else if (m_busy_mode == 0) begin
            for (int k = 0; k < 4; k++)
                if (m_out < 0 && req[order[k]] == 1) m_out = order[k];
            if (m_out >= 0) begin
                m_cmd = m_out; m_hold_left = H - 1; m_busy_mode = 1;
            end
        end else if (m_busy_mode == 1) begin
            if (m_hold_left == 0) begin
                m_out = -1; m_busy_mode = 2; m_rep = 0;
            end else m_hold_left--;
        end else begin
`ifdef SEMI_CMD_AUTOREPEAT_EN
            if (m_deb[m_cmd] == 1) begin
                m_rep++;
                if (m_rep == R) begin
                    m_busy_mode = 1; m_out = m_cmd; m_hold_left = H - 1; m_rep = 0;
                end
            end else begin
                m_rep = 0;
                if (all_low) m_busy_mode = 0;
            end
`else
            if (all_low) m_busy_mode = 0;
`endif
        end
        // A synchronised level must disagree with the clean level for D edges in a row to replace it.
        for (int i = 0; i < 4; i++) begin
            m_debp[i] = m_deb[i];
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_deb[i] = m_s2[i]; m_run[i] = 0;
                end
            end else m_run[i] = 0;
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(raw[i]);
        end
    endtask

    task automatic tick();
        logic [4:0] obs, exp;
        logic [3:0] outs;
        @(posedge clk);
        model_edge(reset, semi_auto_mode_on, {btn_back, btn_straight, btn_right, btn_left});
        #1;
        outs = {turn_back_command, go_straight_command, turn_right_command, turn_left_command};
        obs  = {outs, cmd_busy};
        exp  = {m_out == 3, m_out == 2, m_out == 1, m_out == 0, m_busy_mode != 0};
        check("model_outputs", 32'(obs), 32'(exp));
        check("at_most_one_cmd", 32'($countones(outs) <= 1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (outs[i]) hi_cnt[i]++;
            if (outs[i] && !prev_outs[i]) rise_cnt[i]++;
        end
        prev_outs = outs;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i] = 0; rise_cnt[i] = 0;
        end
    endtask

    initial begin
        int expected_rises;
        prev_outs = '0;
        clear_stats();
        model_edge(1'b1, 1'b0, 4'b0000);

        // Reset state
        ticks(3);
        check("reset_outputs", 32'({turn_left_command, turn_right_command, go_straight_command,
                                   turn_back_command, cmd_busy}), 32'd0);
        reset = 1'b0;
        ticks(2);

        // Held left button: exact latency and stretch length, busy until release
        clear_stats();
        semi_auto_mode_on = 1'b1;
        btn_left = 1'b1;
        ticks(6);
        check("left_before_edge7", 32'(turn_left_command), 32'd0);
        tick();
        check("left_at_edge7", 32'(turn_left_command), 32'd1);
        ticks(7);
        check("left_at_edge14", 32'(turn_left_command), 32'd1);
        tick();
        check("left_off_edge15", 32'(turn_left_command), 32'd0);
        ticks(10);
        check("left_high_cycles", 32'(hi_cnt[0]), 32'd8);
        check("busy_while_held", 32'(cmd_busy), 32'd1);
        btn_left = 1'b0;
        ticks(10);
        check("busy_after_release", 32'(cmd_busy), 32'd0);

        // Short glitch on right never becomes a command
        clear_stats();
        btn_right = 1'b1;
        ticks(3);
        btn_right = 1'b0;
        ticks(15);
        check("glitch_no_cmd", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);

        // Simultaneous straight and back: straight wins, back is discarded
        clear_stats();
        btn_straight = 1'b1;
        btn_back = 1'b1;
        ticks(20);
        btn_straight = 1'b0;
        btn_back = 1'b0;
        ticks(15);
        check("straight_wins_cycles", 32'(hi_cnt[2]), 32'd8);
        check("back_dropped", 32'(hi_cnt[3]), 32'd0);

        // Press with mode off is not replayed; a fresh press works
        clear_stats();
        semi_auto_mode_on = 1'b0;
        btn_back = 1'b1;
        ticks(10);
        semi_auto_mode_on = 1'b1;
        ticks(10);
        check("no_replay", 32'(hi_cnt[3]), 32'd0);
        btn_back = 1'b0;
        ticks(10);
        btn_back = 1'b1;
        ticks(20);
        check("back_fresh_press", 32'(hi_cnt[3]), 32'd8);
        btn_back = 1'b0;
        ticks(10);

        // Reset in the middle of HOLD
        btn_left = 1'b1;
        ticks(9);
        check("mid_hold_active", 32'(turn_left_command), 32'd1);
        reset = 1'b1;
        btn_left = 1'b0;
        tick();
        check("reset_mid_hold", 32'({turn_left_command, turn_right_command, go_straight_command,
                                    turn_back_command, cmd_busy}), 32'd0);
        ticks(2);
        reset = 1'b0;
        ticks(3);

        // Long hold on right: one pulse, or repeats every 8 + 20 cycles with auto-repeat
        clear_stats();
        btn_right = 1'b1;
        ticks(60);
        btn_right = 1'b0;
        ticks(40);
`ifdef SEMI_CMD_AUTOREPEAT_EN
        expected_rises = 3;
`else
        expected_rises = 1;
`endif
        check("right_pulse_count", 32'(rise_cnt[1]), 32'(expected_rises));
        check("right_high_cycles", 32'(hi_cnt[1]), 32'(expected_rises * 8));

        // Randomized buttons, mode and occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(39, 0) == 0) btn_left     = ~btn_left;
            if ($urandom_range(39, 0) == 0) btn_right    = ~btn_right;
            if ($urandom_range(39, 0) == 0) btn_straight = ~btn_straight;
            if ($urandom_range(39, 0) == 0) btn_back     = ~btn_back;
            if ($urandom_range(299, 0) == 0) semi_auto_mode_on = ~semi_auto_mode_on;
            reset = ($urandom_range(499, 0) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
